// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, N+1 cycle latency.
// Optional SEQ_DIVIDER_AUTO_EN: self-start in IDLE when operands differ from last capture.
module seq_divider #(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           I_RST,
    input  logic           START,
    input  logic [2*N-1:0] DIVIDEND,
    input  logic [N-1:0]   DIVISOR,
    output logic           BUSY,
    output logic           DONE,
    output logic [N-1:0]   QUOTIENT,
    output logic [N-1:0]   REMAINDER,
    output logic           DZ,
    output logic           DO
);

    // state  | meaning
    // IDLE   | waiting for START (or operand change when auto-start is built in)
    // RUN    | one restoring step per cycle, N cycles
    // FINISH | results/flags registered on the following edge, DONE pulses
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_t        state, state_nx;
    logic [N-1:0]  r, r_nx;
    logic [N-1:0]  q, q_nx;
    logic [N-1:0]  d, d_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          err_dz, err_dz_nx;
    logic          err_do, err_do_nx;
    logic          go;
    logic [N:0]    shifted;

`ifdef SEQ_DIVIDER_AUTO_EN
    logic [2*N-1:0] sh_dividend;
    logic [N-1:0]   sh_divisor;

    assign go = START || (DIVIDEND != sh_dividend) || (DIVISOR != sh_divisor);

    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) begin
            sh_dividend <= '0;
            sh_divisor  <= '0;
        end else if (state == IDLE && go) begin
            sh_dividend <= DIVIDEND;
            sh_divisor  <= DIVISOR;
        end
    end
`else
    assign go = START;
`endif

    assign shifted = {r, q[N-1]};

    always_comb begin
        state_nx  = state;
        r_nx      = r;
        q_nx      = q;
        d_nx      = d;
        cnt_nx    = cnt;
        err_dz_nx = err_dz;
        err_do_nx = err_do;
        case (state)
            IDLE: begin
                if (go) begin
                    d_nx      = DIVISOR;
                    r_nx      = DIVIDEND[2*N-1:N];
                    q_nx      = DIVIDEND[N-1:0];
                    cnt_nx    = '0;
                    err_dz_nx = (DIVISOR == '0);
                    err_do_nx = (DIVISOR != '0) && (DIVIDEND[2*N-1:N] >= DIVISOR);
                    state_nx  = (err_dz_nx || err_do_nx) ? FINISH : RUN;
                end
            end
            RUN: begin
                // r < d holds here, so the true difference fits in N bits
                if (shifted >= {1'b0, d}) begin
                    r_nx = shifted[N-1:0] - d;
                    q_nx = {q[N-2:0], 1'b1};
                end else begin
                    r_nx = shifted[N-1:0];
                    q_nx = {q[N-2:0], 1'b0};
                end
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(N - 1))
                    state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) begin
            state  <= IDLE;
            r      <= '0;
            q      <= '0;
            d      <= '0;
            cnt    <= '0;
            err_dz <= 1'b0;
            err_do <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nx;
            r      <= r_nx;
            q      <= q_nx;
            d      <= d_nx;
            cnt    <= cnt_nx;
            err_dz <= err_dz_nx;
            err_do <= err_do_nx;
            BUSY   <= (state_nx == RUN);
        end
    end

    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) begin
            DONE      <= 1'b0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            DZ        <= 1'b0;
            DO        <= 1'b0;
        end else if (state == FINISH) begin
            DONE <= 1'b1;
            DZ   <= err_dz;
            DO   <= err_do && !err_dz;
            if (err_dz || err_do) begin
                QUOTIENT  <= '1;
                REMAINDER <= '1;
            end else begin
                QUOTIENT  <= q;
                REMAINDER <= r;
            end
        end else begin
            DONE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8 main instance, N=16 secondary instance).
module tb_seq_divider;

    logic        CLK = 1'b0;
    logic        I_RST;
    logic        START;
    logic [15:0] DIVIDEND;
    logic [7:0]  DIVISOR;
    logic        BUSY, DONE, DZ, DO;
    logic [7:0]  QUOTIENT, REMAINDER;

    logic        start16;
    logic [31:0] dividend16;
    logic [15:0] divisor16;
    logic        busy16, done16, dz16, do16;
    logic [15:0] quot16, rem16;

    int checks = 0;
    int failures = 0;
    int edges;
    int busy_cnt;
    int done_edge;

    always #5 CLK = ~CLK;

    seq_divider #(.N(8)) dut (
        .CLK(CLK), .I_RST(I_RST), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .BUSY(BUSY), .DONE(DONE), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER), .DZ(DZ), .DO(DO)
    );

    seq_divider #(.N(16)) dut16 (
        .CLK(CLK), .I_RST(I_RST), .START(start16), .DIVIDEND(dividend16), .DIVISOR(divisor16),
        .BUSY(busy16), .DONE(done16), .QUOTIENT(quot16), .REMAINDER(rem16), .DZ(dz16), .DO(do16)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        edges++;
        if (BUSY) busy_cnt++;
    endtask

    // START accepted on the returned-from edge, which is edge 0
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        @(negedge CLK);
        DIVIDEND = a;
        DIVISOR  = b;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START    = 1'b0;
        edges    = 0;
        busy_cnt = BUSY ? 1 : 0;
    endtask

    task automatic wait_done(input int max_edges);
        done_edge = -1;
        while (edges < max_edges && done_edge < 0) begin
            tick();
            if (DONE) done_edge = edges;
        end
    endtask

    task automatic check_result(input string tag, input int exp_edge, input int exp_busy,
                                input logic [7:0] exp_q, input logic [7:0] exp_r,
                                input logic exp_dz, input logic exp_do);
        check({tag, "_done_edge"}, done_edge, exp_edge);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_quotient"}, QUOTIENT, exp_q);
        check({tag, "_remainder"}, REMAINDER, exp_r);
        check({tag, "_dz"}, DZ, exp_dz);
        check({tag, "_do"}, DO, exp_do);
    endtask

    initial begin
        I_RST = 1'b1; START = 1'b0; DIVIDEND = '0; DIVISOR = '0;
        start16 = 1'b0; dividend16 = '0; divisor16 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check("reset_quotient", QUOTIENT, 0);
        check("reset_remainder", REMAINDER, 0);
        check("reset_flags", {DZ, DO}, 0);
        @(negedge CLK);
        I_RST = 1'b0;

`ifdef SEQ_DIVIDER_AUTO_EN
        // START stays 0: operand edits alone launch operations
        @(negedge CLK);
        DIVIDEND = 16'd1000;
        DIVISOR  = 8'd7;
        edges = -1; busy_cnt = 0;
        wait_done(40);
        check("auto1_done_edge", done_edge, 9);
        check("auto1_quotient", QUOTIENT, 142);
        check("auto1_remainder", REMAINDER, 6);
        @(negedge CLK);
        DIVISOR = 8'd9;
        edges = -1; busy_cnt = 0;
        wait_done(40);
        check("auto2_done_edge", done_edge, 9);
        check("auto2_busy_cycles", busy_cnt, 8);
        check("auto2_quotient", QUOTIENT, 111);
        check("auto2_remainder", REMAINDER, 1);
        edges = 0;
        wait_done(30);
        check("auto_no_restart", done_edge, -1);
        check("auto_idle_busy", BUSY, 0);
`else
        // 1000 / 7 = 142 r 6
        start_op(16'h03E8, 8'd7);
        wait_done(40);
        check_result("div1000_7", 9, 8, 8'd142, 8'd6, 0, 0);
        tick();
        check("done_one_cycle", DONE, 0);
        check("result_held_q", QUOTIENT, 142);

        start_op(16'h1234, 8'h00);
        wait_done(40);
        check_result("divzero", 1, 0, 8'hFF, 8'hFF, 1, 0);

        start_op(16'h0800, 8'h08);
        wait_done(40);
        check_result("overflow", 1, 0, 8'hFF, 8'hFF, 0, 1);

        // 2047 / 8 = 255 r 7, largest quotient without overflow
        start_op(16'h07FF, 8'h08);
        wait_done(40);
        check_result("max_quot", 9, 8, 8'hFF, 8'd7, 0, 0);

        // 255 / 16 = 15 r 15; a START pulse at edge 3 with new operands is ignored
        start_op(16'h00FF, 8'h10);
        repeat (2) tick();
        @(negedge CLK);
        START = 1'b1; DIVIDEND = 16'hFFFF; DIVISOR = 8'hFF;
        tick();
        START = 1'b0;
        wait_done(40);
        check_result("ignore_start", 9, 8, 8'h0F, 8'h0F, 0, 0);

        // START held: second accept on first IDLE cycle after FINISH
        start_op(16'h03E8, 8'd7);
        START = 1'b1;
        wait_done(40);
        check("b2b_first_edge", done_edge, 9);
        tick();
        START = 1'b0;
        check("b2b_second_accept", BUSY, 1);
        wait_done(40);
        check("b2b_second_edge", done_edge, 19);
        check("b2b_quotient", QUOTIENT, 142);

        // reset mid-RUN clears outputs without a clock edge
        start_op(16'h00FF, 8'h10);
        repeat (3) tick();
        check("pre_reset_busy", BUSY, 1);
        #2;
        I_RST = 1'b1;
        #1;
        check("rst_async_busy", BUSY, 0);
        check("rst_async_quotient", QUOTIENT, 0);
        check("rst_async_remainder", REMAINDER, 0);
        check("rst_async_flags", {DONE, DZ, DO}, 0);
        @(negedge CLK);
        I_RST = 1'b0;
        edges = 0;
        wait_done(15);
        check("rst_no_done", done_edge, -1);

        // N=16: 0x12345678 / 0x9ABC = 7710 r 11376
        @(negedge CLK);
        dividend16 = 32'h12345678;
        divisor16  = 16'h9ABC;
        start16    = 1'b1;
        @(posedge CLK);
        #1;
        start16 = 1'b0;
        edges = 0; done_edge = -1;
        while (edges < 60 && done_edge < 0) begin
            @(posedge CLK);
            #1;
            edges++;
            if (done16) done_edge = edges;
        end
        check("n16_done_edge", done_edge, 17);
        check("n16_quotient", quot16, 16'h1E1E);
        check("n16_remainder", rem16, 16'h2C70);
        check("n16_flags", {dz16, do16}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
